// File: rtl/simple_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : simple_multicycle_ctrl
// Purpose  : Multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit for SIMPLE.
//            Optional macro CU_PERF_CNT_EN adds the insn_count output.
// Revision : 1.0
// ============================================================================
module simple_multicycle_ctrl #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic [15:0]       COMMAND,
  input  logic [3:0]        SZCV,
  input  logic              mem_ack,
  output logic [3:0]        S_ALU,
  output logic [DATA_W-1:0] immidiate,
  output logic [REG_AW-1:0] writeAddress,
  output logic              AR_MUX,
  output logic              BR_MUX,
  output logic              ADR_MUX,
  output logic              INPUT_MUX,
  output logic              write,
  output logic              ir_load,
  output logic              pc_inc,
  output logic              PC_load,
  output logic              mem_req,
  output logic              mem_we,
  output logic              szcv_load,
  output logic              halted
`ifdef CU_PERF_CNT_EN
  ,
  output logic [31:0]       insn_count
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [15:0]         r_ir;
  logic                r_mem_req;

  logic [3:0]          r_alu;
  logic [DATA_W-1:0]   r_imm;
  logic [2:0]          r_wa;
  logic                r_ar, r_br, r_inmux, r_wen, r_flag;
  logic                r_ld, r_st, r_b, r_bcc, r_halt;
  logic [2:0]          r_cond;

  logic [3:0]          w_alu;
  logic [DATA_W-1:0]   w_imm;
  logic [2:0]          w_wa;
  logic                w_ar, w_br, w_inmux, w_wen, w_flag;
  logic                w_ld, w_st, w_b, w_bcc, w_halt;

  logic [1:0]          w_op1;
  logic [3:0]          w_op3;
  logic [DATA_W-1:0]   w_sext;
  logic [DATA_W-1:0]   w_zext;
  logic                w_ack;
  logic                w_cond_true;
  logic                w_taken;
  logic                w_unused;

  assign w_op1  = r_ir[15:14];
  assign w_op3  = r_ir[7:4];
  assign w_sext = DATA_W'($signed(r_ir[7:0]));
  assign w_zext = DATA_W'(r_ir[3:0]);
  // A handshake only counts while our registered request is actually up
  assign w_ack  = r_mem_req & mem_ack;
  assign w_unused = SZCV[1];

  // Instruction decode from the latched instruction register
  always_comb begin
    w_alu   = 4'b1111;
    w_imm   = '0;
    w_wa    = 3'd0;
    w_ar    = 1'b0;
    w_br    = 1'b0;
    w_inmux = 1'b0;
    w_wen   = 1'b0;
    w_flag  = 1'b0;
    w_ld    = 1'b0;
    w_st    = 1'b0;
    w_b     = 1'b0;
    w_bcc   = 1'b0;
    w_halt  = 1'b0;
    case (w_op1)
      2'b00: begin
        w_alu = 4'b0000; w_imm = w_sext; w_wa = r_ir[13:11];
        w_ar  = 1'b1;    w_wen = 1'b1;   w_ld = 1'b1;
      end
      2'b01: begin
        w_alu = 4'b0000; w_imm = w_sext; w_ar = 1'b1; w_st = 1'b1;
      end
      2'b10: begin
        case (r_ir[13:11])
          3'b000: begin
            w_alu = 4'b1111; w_imm = w_sext; w_wa = r_ir[10:8]; w_wen = 1'b1;
          end
          3'b100: begin
            w_alu = 4'b0000; w_imm = w_sext; w_b = 1'b1;
          end
          3'b111: begin
            w_alu = 4'b0000; w_imm = w_sext; w_bcc = 1'b1;
          end
          default: ;
        endcase
      end
      default: begin
        w_alu = w_op3;
        w_ar  = 1'b1;
        w_br  = 1'b1;
        w_wa  = r_ir[10:8];
        case (w_op3)
          4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0110: begin
            w_wen = 1'b1; w_flag = 1'b1;
          end
          4'b0101: w_flag = 1'b1;
          4'b1000, 4'b1001, 4'b1010, 4'b1011: begin
            w_br = 1'b0; w_imm = w_zext; w_wen = 1'b1; w_flag = 1'b1;
          end
          4'b1100: begin
            w_wen = 1'b1; w_inmux = 1'b1;
          end
          4'b1111: w_halt = 1'b1;
          default: ;
        endcase
      end
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_state   <= S_FETCH;
      r_mem_req <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_mem_req <= (w_next == S_FETCH) || (w_next == S_MEM);
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_ir    <= '0;
      r_alu   <= 4'b1111;
      r_imm   <= '0;
      r_wa    <= 3'd0;
      r_ar    <= 1'b0;
      r_br    <= 1'b0;
      r_inmux <= 1'b0;
      r_wen   <= 1'b0;
      r_flag  <= 1'b0;
      r_ld    <= 1'b0;
      r_st    <= 1'b0;
      r_b     <= 1'b0;
      r_bcc   <= 1'b0;
      r_halt  <= 1'b0;
      r_cond  <= 3'd0;
    end else begin
      if (ir_load) r_ir <= COMMAND;
      if (r_state == S_DECODE) begin
        r_alu   <= w_alu;
        r_imm   <= w_imm;
        r_wa    <= w_wa;
        r_ar    <= w_ar;
        r_br    <= w_br;
        r_inmux <= w_inmux;
        r_wen   <= w_wen;
        r_flag  <= w_flag;
        r_ld    <= w_ld;
        r_st    <= w_st;
        r_b     <= w_b;
        r_bcc   <= w_bcc;
        r_halt  <= w_halt;
        r_cond  <= r_ir[10:8];
      end
    end
  end

  // Branch condition evaluated on the live flags during WB
  always_comb begin
    w_cond_true = 1'b0;
    case (r_cond)
      3'b000: w_cond_true = SZCV[2];
      3'b001: w_cond_true = SZCV[3] ^ SZCV[0];
      3'b010: w_cond_true = SZCV[2] | (SZCV[3] ^ SZCV[0]);
      3'b011: w_cond_true = ~SZCV[2];
      default: w_cond_true = 1'b0;
    endcase
  end
  assign w_taken = r_b | (r_bcc & w_cond_true);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (w_ack) w_next = S_DECODE;
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        if (r_halt)            w_next = S_HALT;
        else if (r_ld || r_st) w_next = S_MEM;
        else                   w_next = S_WB;
      end
      S_MEM:    if (w_ack) w_next = r_st ? S_FETCH : S_WB;
      S_WB:     w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_FETCH;
    endcase
  end

  always_comb begin
    writeAddress      = '0;
    writeAddress[2:0] = r_wa;
  end

  assign S_ALU     = r_alu;
  assign immidiate = r_imm;
  assign AR_MUX    = r_ar;
  assign BR_MUX    = r_br;
  assign INPUT_MUX = r_inmux;
  assign ADR_MUX   = (r_state == S_MEM);
  assign mem_req   = r_mem_req;
  assign mem_we    = (r_state == S_MEM) & r_st;
  assign ir_load   = (r_state == S_FETCH) & w_ack;
  assign pc_inc    = (r_state == S_FETCH) & w_ack;
  assign szcv_load = (r_state == S_EXEC) & r_flag;
  assign write     = (r_state == S_WB) & r_wen;
  assign PC_load   = (r_state == S_WB) & w_taken;
  assign halted    = (r_state == S_HALT);

`ifdef CU_PERF_CNT_EN
  logic [31:0] r_insn_count;
  logic        w_insn_done;

  assign w_insn_done = (r_state == S_WB)
                     | ((r_state == S_MEM) & w_ack & r_st)
                     | ((r_state == S_EXEC) & r_halt);

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET)           r_insn_count <= 32'd0;
    else if (w_insn_done) r_insn_count <= r_insn_count + 32'd1;
  end
  assign insn_count = r_insn_count;
`endif

endmodule
`default_nettype wire

// File: doc/simple_multicycle_ctrl.md
Name: simple_multicycle_ctrl

Overview:
Parametrised multi-cycle control unit for the SIMPLE 16-bit-instruction processor, replacing the single-phase decoder.
- Sequences each instruction through a FETCH/DECODE/EXEC/MEM/WB phase machine.
- Stalls on a req/ack memory handshake.
- Evaluates conditional branches from SZCV.
- Drives all datapath mux selects, register write and PC controls.
- Datapath width is parametrised; the instruction word is fixed at 16 bits.

Parameters:
DATA_W, 16, datapath width; sets the width of immediate and the sign-extension target.
REG_AW, 3, register address width; must be ≥3, upper bits of writeAddress are zero.

Ports:
CLOCK  in  1  system clock, rising edge
RESET  in  1  asynchronous, active-low reset
COMMAND  in  16  instruction word; valid while mem_ack is high in FETCH
SZCV  in  4  flags from ALU flag register: [3]S [2]Z [1]C [0]V
mem_ack  in  1  memory transfer complete
S_ALU  out  4  ALU operation select
immidiate  out  DATA_W  extended immediate
writeAddress  out  REG_AW  register-file write address
AR_MUX  out  1  ALU A source: 1=register, 0=PC
BR_MUX  out  1  ALU B source: 1=register, 0=immidiate
ADR_MUX  out  1  memory address: 0=PC, 1=ALU result
INPUT_MUX  out  1  writeback source: 1=external input port, 0=ALU/memory
write  out  1  register-file write enable, one cycle
ir_load  out  1  instruction-register load strobe
pc_inc  out  1  PC+1 strobe
PC_load  out  1  load PC from ALU result
mem_req  out  1  memory request
mem_we  out  1  memory write qualifier for mem_req
szcv_load  out  1  flag-register update strobe
halted  out  1  HLT executed

Behaviour:
- Reset (RESET=0, async):
  - state=FETCH.
  - All strobes, mem_req, mem_we and halted are 0.
  - S_ALU=4'b1111 (pass-through), immidiate=0, writeAddress=0, all muxes 0.
  - Reset mid-transfer drops mem_req immediately; no pending write survives.
- FETCH:
  - mem_req=1, ADR_MUX=0, mem_we=0.
  - On the posedge with mem_ack=1: latch COMMAND, pulse ir_load and pc_inc, go to DECODE.
- DECODE (1 cycle):
  - Latch the decoded controls.
  - immidiate: sign-extend COMMAND[7:0] to DATA_W for LD/ST/LI/B/Bcc; zero-extend [3:0] for shifts (op3 1000–1011).
- EXEC (1 cycle):
  - Arithmetic (op1=11): S_ALU=op3; AR_MUX=1, BR_MUX=1; shifts use BR_MUX=0; szcv_load=1 for op3 0000–0110 and 1000–1011.
  - LD/ST: S_ALU=ADD, AR_MUX=1, BR_MUX=0 (base Rb + d).
  - LI: S_ALU=1111, BR_MUX=0.
  - B/Bcc: AR_MUX=0, BR_MUX=0 (target = PC+d, PC already incremented).
- MEM (LD/ST only):
  - mem_req=1, ADR_MUX=1, mem_we=1 for ST.
  - Hold until mem_ack, then go to WB (LD) or FETCH (ST).
- WB (1 cycle):
  - write=1 for ADD,SUB,AND,OR,XOR,MOV, shifts, IN, LD, LI; INPUT_MUX=1 only for IN.
  - writeAddress=COMMAND[10:8] for arithmetic/LI; COMMAND[13:11] for LD.
  - CMP and OUT (op3 0101/1101) make no write.
  - Branch: PC_load=1 if taken. B always taken.
  - Bcc conditions on [10:8]: 000 BE Z; 001 BLT S^V; 010 BLE Z|(S^V); 011 BNE !Z; others never taken.
  - SZCV is sampled in WB.
- HLT (op1=11, op3=1111): EXEC→HALT; halted=1; only reset exits.
- Undefined opcodes act as NOP (no write, no PC_load).
- Latency with zero-wait memory:
  - ALU/LI/branch: 4 cycles.
  - LD: 5 cycles.
  - ST: 4 cycles (FETCH, DECODE, EXEC, MEM; no WB).
  - Each extra cycle of mem_ack=0 adds one cycle.
- mem_req is a registered output.
  - Once asserted it stays high until the ack cycle.
  - It deasserts the cycle after ack.
  - A spurious mem_ack outside FETCH/MEM is ignored.

Optional Feature:
CU_PERF_CNT_EN:
- Defined: adds output insn_count [31:0].
  - Increments at the end of each completed instruction (WB, or MEM for ST); HLT counts once.
  - Reset to 0; wraps 0xFFFFFFFF→0.
- Undefined: port and counter are absent; behaviour otherwise identical.

Test Plan:
- Reset, mem_ack=1 always, COMMAND=0xC100 (ADD r0,r1): ir_load at cycle 1, szcv_load in EXEC, write=1 with writeAddress=1 at cycle 4, S_ALU=0000.
- LD 16'h0AFE (Ra=1, Rb=2, d=-2), mem_ack low for 3 cycles in MEM: immidiate=0xFFFE, mem_req held 4 cycles, write=1 with writeAddress=1 in WB, total 8 cycles.
- ST 16'h4A05: mem_we=1 with ADR_MUX=1 in MEM, write never asserted, returns to FETCH after 4 cycles.
- BLT 0xB9F0 with SZCV=4'b1000: PC_load=1. With SZCV=4'b1001: PC_load=0. BNE 0xBB10 with Z=1: PC_load=0.
- HLT 0xC0F0: halted=1 from cycle after EXEC; mem_req stays 0 for 20 cycles. RESET low mid-MEM of an LD: mem_req=0 immediately, state FETCH after release.
- With CU_PERF_CNT_EN: 3 ADDs then HLT gives insn_count=4.
